fport_encode: RTL and testbench

- Builds and serialises one FPort control frame per start request.
- Input: 16 RC channels, a flags byte and an RSSI byte.
- Output: a byte stream with framing, byte-stuffing and checksum, handed to a uart_tx via a byte-wide send/busy handshake.
- Used on the RC-receiver side of the FPort link (bench stimulus generator, loopback self-test) to drive the flight controller's FPort decoder.

---
 rtl/fport_pkg.sv | 38 +++
 rtl/fport_crc8_acc.sv | 33 +++
 rtl/fport_encode.sv | 143 ++++++++++++++
 tb/tb_fport_encode.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/fport_pkg.sv
// rtl/fport_pkg.sv - FPort framing constants and FSM states shared by encoder and decoder
package fport_pkg;

    localparam logic [7:0] FPORT_DELIM     = 8'h7E;
    localparam logic [7:0] FPORT_ESC       = 8'h7D;
    localparam logic [7:0] FPORT_XOR       = 8'h20;
    localparam logic [7:0] FPORT_LEN_CTRL  = 8'h19;
    localparam logic [7:0] FPORT_TYPE_CTRL = 8'h00;

    localparam int NUM_CHANNELS    = 16;
    localparam int CH_BITS         = 11;
    localparam int CTRL_DATA_BYTES = 22;

    // Raw frame byte positions: head, LEN, TYPE, D0..D21, flags, rssi, CRC, tail
    localparam logic [4:0] IDX_LEN   = 5'd1;
    localparam logic [4:0] IDX_TYPE  = 5'd2;
    localparam logic [4:0] IDX_D0    = 5'd3;
    localparam logic [4:0] IDX_D21   = 5'd24;
    localparam logic [4:0] IDX_FLAGS = 5'd25;
    localparam logic [4:0] IDX_RSSI  = 5'd26;
    localparam logic [4:0] IDX_CRC   = 5'd27;
    localparam logic [4:0] IDX_TAIL  = 5'd28;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_WAIT_TX,
        ST_SEND,
        ST_GUARD,
        ST_NEXT,
        ST_DONE
    } fport_state_e;

    function automatic logic fport_needs_stuff(input logic [7:0] b);
        return (b == FPORT_DELIM) || (b == FPORT_ESC);
    endfunction

endpackage

// File: rtl/fport_crc8_acc.sv
// rtl/fport_crc8_acc.sv - FPort end-around-carry byte accumulator and checksum
module fport_crc8_acc (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       clear_i,
    input  logic       add_i,
    input  logic [7:0] byte_i,
    output logic [7:0] crc_o
);
    logic [7:0] acc_q, acc_d;
    logic [8:0] sum;

    always_comb begin
        sum   = {1'b0, acc_q} + {1'b0, byte_i};
        acc_d = acc_q;
        if (clear_i) begin
            acc_d = 8'h00;
        end else if (add_i) begin
            acc_d = sum[7:0] + {7'b0, sum[8]};
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            acc_q <= 8'h00;
        end else begin
            acc_q <= acc_d;
        end
    end

    assign crc_o = 8'hFF - acc_q;

endmodule

// File: rtl/fport_encode.sv
// rtl/fport_encode.sv - builds, stuffs and serialises one FPort control frame per start
module fport_encode
    import fport_pkg::*;
#(
    parameter int NUM_CHANNELS = 16,
    parameter int CH_BITS      = 11
) (
    input  logic                            clock,
    input  logic                            reset,
    input  logic                            start,
    input  logic [NUM_CHANNELS*CH_BITS-1:0] channels,
    input  logic [7:0]                      flags,
    input  logic [7:0]                      rssi,
    input  logic                            tx_busy,
    output logic [7:0]                      tx_data,
    output logic                            tx_send,
    output logic                            busy,
    output logic                            frame_done
);
    localparam int CH_W = NUM_CHANNELS * CH_BITS;

    fport_state_e state_q, state_d;
    logic [4:0]   idx_q, idx_d;
    logic         esc_q, esc_d;
    logic [7:0]   data_q, data_d;
    logic [CH_W-1:0] sh_ch_q;
    logic [7:0]   sh_flags_q, sh_rssi_q;

    logic         accept;
    logic         crc_clear, crc_add;
    logic [7:0]   crc_byte;
    logic [4:0]   sel_idx;
    logic [4:0]   d_idx;
    logic [7:0]   raw;

    fport_crc8_acc u_crc (
        .clk_i   (clock),
        .rst_i   (reset),
        .clear_i (crc_clear),
        .add_i   (crc_add),
        .byte_i  (raw),
        .crc_o   (crc_byte)
    );

    // While an escape is pending the current byte is re-read for its XORed form
    assign sel_idx = esc_q ? idx_q : idx_q + 5'd1;
    assign d_idx   = sel_idx - IDX_D0;

    always_comb begin
        raw = 8'h00;
        if (sel_idx == 5'd0 || sel_idx == IDX_TAIL) raw = FPORT_DELIM;
        else if (sel_idx == IDX_LEN)                raw = FPORT_LEN_CTRL;
        else if (sel_idx == IDX_TYPE)               raw = FPORT_TYPE_CTRL;
        else if (sel_idx <= IDX_D21)                raw = sh_ch_q[{d_idx, 3'b000} +: 8];
        else if (sel_idx == IDX_FLAGS)              raw = sh_flags_q;
        else if (sel_idx == IDX_RSSI)               raw = sh_rssi_q;
        else if (sel_idx == IDX_CRC)                raw = crc_byte;
    end

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        esc_d      = esc_q;
        data_d     = data_q;
        accept     = 1'b0;
        crc_clear  = 1'b0;
        crc_add    = 1'b0;
        tx_send    = 1'b0;
        busy       = 1'b1;
        frame_done = 1'b0;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                busy       = 1'b0;
                frame_done = (state_q == ST_DONE);
                state_d    = ST_IDLE;
                if (start) begin
                    accept    = 1'b1;
                    crc_clear = 1'b1;
                    state_d   = ST_LOAD;
                end
            end
            ST_LOAD: begin
                idx_d   = 5'd0;
                esc_d   = 1'b0;
                data_d  = FPORT_DELIM;
                state_d = ST_WAIT_TX;
            end
            ST_WAIT_TX: begin
                if (!tx_busy) state_d = ST_SEND;
            end
            ST_SEND: begin
                tx_send = 1'b1;
                state_d = ST_GUARD;
            end
            ST_GUARD: begin
                state_d = (idx_q == IDX_TAIL && !esc_q) ? ST_DONE : ST_NEXT;
            end
            ST_NEXT: begin
                state_d = ST_WAIT_TX;
                if (esc_q) begin
                    data_d = raw ^ FPORT_XOR;
                    esc_d  = 1'b0;
                end else begin
                    idx_d   = sel_idx;
                    // Folding at selection time keeps the CRC complete before IDX_CRC is read
                    crc_add = (sel_idx >= IDX_LEN) && (sel_idx <= IDX_RSSI);
                    if ((sel_idx >= IDX_LEN) && (sel_idx <= IDX_CRC) && fport_needs_stuff(raw)) begin
                        data_d = FPORT_ESC;
                        esc_d  = 1'b1;
                    end else begin
                        data_d = raw;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            idx_q      <= 5'd0;
            esc_q      <= 1'b0;
            data_q     <= 8'h00;
            sh_ch_q    <= '0;
            sh_flags_q <= 8'h00;
            sh_rssi_q  <= 8'h00;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            esc_q   <= esc_d;
            data_q  <= data_d;
            if (accept) begin
                sh_ch_q    <= channels;
                sh_flags_q <= flags;
                sh_rssi_q  <= rssi;
            end
        end
    end

    assign tx_data = data_q;

endmodule

// File: tb/tb_fport_encode.sv
// tb/tb_fport_encode.sv - randomized self-checking bench for fport_encode against a frame model
module tb_fport_encode;

    logic         clock = 1'b0;
    logic         reset;
    logic         start;
    logic [175:0] channels;
    logic [7:0]   flags;
    logic [7:0]   rssi;
    logic         tx_busy;
    logic [7:0]   tx_data;
    logic         tx_send;
    logic         busy;
    logic         frame_done;

    fport_encode #(.NUM_CHANNELS(16), .CH_BITS(11)) dut (
        .clock      (clock),
        .reset      (reset),
        .start      (start),
        .channels   (channels),
        .flags      (flags),
        .rssi       (rssi),
        .tx_busy    (tx_busy),
        .tx_data    (tx_data),
        .tx_send    (tx_send),
        .busy       (busy),
        .frame_done (frame_done)
    );

    initial forever #5 clock = ~clock;

    int checks = 0;
    int passes = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    logic [7:0] exp_q[$];

    // Frame model: byte list from the layout, checksum as a ones'-complement sum
    task automatic model_frame(input logic [175:0] ch, input logic [7:0] fl, input logic [7:0] rs,
                               output logic [7:0] crc, output int nwire);
        logic [7:0] raw [29];
        int sum;
        int acc;
        raw[0] = 8'h7E;
        raw[1] = 8'h19;
        raw[2] = 8'h00;
        for (int k = 0; k < 22; k++) raw[3+k] = ch[8*k +: 8];
        raw[25] = fl;
        raw[26] = rs;
        sum = 0;
        for (int i = 1; i <= 26; i++) sum += int'(raw[i]);
        acc = (sum == 0) ? 0 : ((sum - 1) % 255) + 1;
        crc = 8'(255 - acc);
        raw[27] = crc;
        raw[28] = 8'h7E;
        nwire = 0;
        for (int i = 0; i < 29; i++) begin
            if (i > 0 && i < 28 && (raw[i] == 8'h7E || raw[i] == 8'h7D)) begin
                exp_q.push_back(8'h7D);
                exp_q.push_back(raw[i] ^ 8'h20);
                nwire += 2;
            end else begin
                exp_q.push_back(raw[i]);
                nwire += 1;
            end
        end
    endtask

    // uart_tx stand-in: busy for busy_len cycles after each send, or while stalled
    int busy_left = 0;
    int busy_len  = 10;
    bit stall     = 1'b0;
    initial begin
        tx_busy = 1'b0;
        forever begin
            @(negedge clock);
            if (tx_send === 1'b1) busy_left = busy_len;
            else if (busy_left > 0) busy_left--;
            tx_busy = stall || (busy_left > 0);
        end
    end

    int sends       = 0;
    int done_cnt    = 0;
    int gap         = 100;
    int stall_sends = 0;
    initial begin
        forever begin
            @(negedge clock);
            gap++;
            if (reset === 1'b0 && tx_send === 1'b1) begin
                check($sformatf("send_spacing_%0d", sends), 32'(gap >= 3), 1);
                if (stall) stall_sends++;
                if (exp_q.size() == 0) check($sformatf("unexpected_send_%0d", sends), 1, 0);
                else check($sformatf("wire_byte_%0d", sends), tx_data, exp_q.pop_front());
                sends++;
                gap = 0;
            end
            if (frame_done === 1'b1) begin
                done_cnt++;
                check("done_queue_empty", exp_q.size(), 0);
                check("busy_low_at_done", busy, 0);
            end
        end
    end

    task automatic pulse_start();
        @(negedge clock);
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
    endtask

    task automatic run_frame(input logic [175:0] ch, input logic [7:0] fl, input logic [7:0] rs,
                             input bit stress, output logic [7:0] crc, output int nwire);
        int d0;
        int s0;
        model_frame(ch, fl, rs, crc, nwire);
        channels = ch;
        flags    = fl;
        rssi     = rs;
        d0 = done_cnt;
        s0 = sends;
        pulse_start();
        check("busy_after_accept", busy, 1);
        channels = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom[15:0]};
        flags    = 8'($urandom);
        rssi     = 8'($urandom);
        if (stress) begin
            for (int i = 0; i < 200 && sends == s0; i++) @(negedge clock);
            check("first_byte_seen", 32'(sends > s0), 1);
            stall_sends = 0;
            stall = 1'b1;
            repeat (200) @(negedge clock);
            check("no_send_while_stalled", stall_sends, 0);
            check("busy_held_while_stalled", busy, 1);
            stall = 1'b0;
            repeat (20) @(negedge clock);
            pulse_start();
        end
        for (int i = 0; i < 20000 && done_cnt == d0; i++) @(negedge clock);
        check("frame_completed", 32'(done_cnt > d0), 1);
        repeat (6) @(negedge clock);
        check("single_frame_done", done_cnt - d0, 1);
        check("idle_after_frame", busy, 0);
        check("wire_byte_count", sends - s0, nwire);
    endtask

    function automatic logic [175:0] rand_channels();
        logic [175:0] v;
        for (int k = 0; k < 22; k++) begin
            case ($urandom_range(0, 7))
                0:       v[8*k +: 8] = 8'h7E;
                1:       v[8*k +: 8] = 8'h7D;
                default: v[8*k +: 8] = 8'($urandom);
            endcase
        end
        return v;
    endfunction

    initial begin
        logic [7:0]   crc;
        int           nw;
        logic [175:0] ch;
        int           s0;
        reset    = 1'b1;
        start    = 1'b0;
        channels = '0;
        flags    = 8'h00;
        rssi     = 8'h00;
        repeat (3) @(negedge clock);
        check("reset_tx_data", tx_data, 0);
        check("reset_tx_send", tx_send, 0);
        check("reset_busy", busy, 0);
        check("reset_frame_done", frame_done, 0);
        reset = 1'b0;
        repeat (2) @(negedge clock);

        busy_len = 10;
        run_frame('0, 8'h00, 8'h00, 1'b0, crc, nw);
        check("crc_all_zero", crc, 8'hE6);
        check("len_all_zero", nw, 29);

        busy_len = 3;
        ch = '0;
        ch[10:0] = 11'h07E;
        run_frame(ch, 8'h00, 8'h00, 1'b0, crc, nw);
        check("crc_d0_7e", crc, 8'h68);
        check("len_d0_7e", nw, 30);

        busy_len = 1;
        run_frame('0, 8'h00, 8'h7D, 1'b0, crc, nw);
        check("crc_rssi_7d", crc, 8'h69);
        check("len_rssi_7d", nw, 30);

        busy_len = 5;
        run_frame({176{1'b1}}, 8'h00, 8'h00, 1'b0, crc, nw);
        check("crc_all_ff", crc, 8'hE6);
        check("len_all_ff", nw, 29);

        busy_len = 4;
        run_frame(rand_channels(), 8'h7E, 8'($urandom), 1'b1, crc, nw);

        for (int f = 0; f < 6; f++) begin
            busy_len = int'($urandom_range(1, 12));
            run_frame(rand_channels(), 8'($urandom), ($urandom_range(0, 2) == 0) ? 8'h7D : 8'($urandom),
                      1'b0, crc, nw);
        end

        busy_len = 2;
        ch = rand_channels();
        model_frame(ch, 8'h5A, 8'hA5, crc, nw);
        channels = ch;
        flags    = 8'h5A;
        rssi     = 8'hA5;
        s0 = sends;
        pulse_start();
        for (int i = 0; i < 2000 && (sends - s0) < 10; i++) @(negedge clock);
        check("reached_byte_10", 32'((sends - s0) >= 10), 1);
        reset = 1'b1;
        @(negedge clock);
        check("abort_tx_send", tx_send, 0);
        check("abort_busy", busy, 0);
        check("abort_frame_done", frame_done, 0);
        reset = 1'b0;
        exp_q.delete();
        repeat (40) @(negedge clock);
        check("no_send_after_abort", sends - s0, 10);
        run_frame(rand_channels(), 8'($urandom), 8'($urandom), 1'b0, crc, nw);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

    initial begin
        #5000000;
        $display("FAIL global_timeout: simulation did not finish, expected completion");
        $fatal(1);
    end

endmodule
